row_packer: RTL

- Upstream neighbour of the one-row-per-clock RGB median filter.
- Accepts a serial RGB pixel stream through a valid/ready handshake and packs ROW pixels into one ROW*WIDTH*3-bit row word.
- Presents completed rows on a valid/ready output that feeds the filter's row input.
- Double-buffered (fill buffer plus output buffer), so a new row can be assembled while the previous row waits to be consumed.
- Tags each row with its index and marks the last row of the frame.

---
 rtl/row_packer.sv | 68 ++++++
 1 files changed

// File: rtl/row_packer.sv
// row_packer: packs a valid/ready RGB pixel stream into double-buffered row words tagged with row index and last-row flag
module row_packer #(
  parameter int ROW   = 256,
  parameter int WIDTH = 8,
  parameter int NROWS = 256
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [3*WIDTH-1:0]         pix_in,
  input  logic                       pix_sof,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [ROW*WIDTH*3-1:0]     row_out,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [$clog2(NROWS)-1:0]   row_idx,
  output logic                       row_last,
  output logic                       sof_err
);
  localparam int PW = 3 * WIDTH;
  localparam int RW = ROW * PW;
  localparam int CW = ROW > 1 ? $clog2(ROW) : 1;
  localparam int IW = $clog2(NROWS);
  logic [RW-1:0] fill_data, fill_next;
  logic [CW-1:0] fill_cnt, slot;
  logic [IW-1:0] frame_cnt, frame_cur;
  logic fill_full, accept, sof_acc, last_pix, complete, out_free, xfer;
  always_comb begin
    pix_ready = !fill_full;
    accept    = pix_valid && pix_ready;
    sof_acc   = accept && pix_sof;
    slot      = sof_acc ? '0 : fill_cnt;
    last_pix  = accept && slot == CW'(ROW - 1);
    complete  = fill_full || last_pix;
    out_free  = !row_valid || row_ready;
    xfer      = complete && out_free;
    frame_cur = sof_acc ? '0 : frame_cnt;
    fill_next = fill_data;
    if (accept) fill_next[(ROW - 1 - int'(slot)) * PW +: PW] = pix_in;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      fill_data <= '0;
      fill_cnt  <= '0;
      fill_full <= 1'b0;
      frame_cnt <= '0;
      row_out   <= '0;
      row_valid <= 1'b0;
      row_idx   <= '0;
      row_last  <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      fill_data <= fill_next;
      fill_cnt  <= accept ? (last_pix ? '0 : slot + CW'(1)) : fill_cnt;
      fill_full <= complete && !out_free;
      sof_err   <= sof_acc && fill_cnt != '0;
      row_valid <= xfer || (row_valid && !row_ready);
      if (xfer) begin
        row_out   <= fill_next;
        row_idx   <= frame_cur;
        row_last  <= frame_cur == IW'(NROWS - 1);
        frame_cnt <= frame_cur == IW'(NROWS - 1) ? '0 : frame_cur + IW'(1);
      end else if (sof_acc) begin
        frame_cnt <= '0;
      end
    end
  end
endmodule
